// File: rtl/vote_ctrl.sv
// vote_ctrl: 5-voter ballot collector with per-voter ack, TIMEOUT-bounded COLLECT, 3-of-5 bitwise majority result, count and timed_out, done pulse
module vote_ctrl #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [4:0]  vld,
  input  logic [14:0] ballots,
  output logic [4:0]  ack,
  output logic        busy,
  output logic        done,
  output logic [2:0]  result,
  output logic [2:0]  count,
  output logic        timed_out
);
  typedef enum logic [1:0] {IDLE, COLLECT, DECIDE, DONE} state_t;
  state_t      state;
  logic [7:0]  timer;
  logic [4:0]  rcv, take, rcv_n;
  logic [14:0] store, tmask;
  logic [2:0]  maj, cnt;
  logic        last;
  function automatic logic [2:0] popcnt(input logic [4:0] v);
    popcnt = 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]) + 3'(v[4]);
  endfunction
  always_comb begin
    take  = state == COLLECT ? vld & ~rcv : 5'd0;
    rcv_n = rcv | take;
    tmask = {{3{take[4]}}, {3{take[3]}}, {3{take[2]}}, {3{take[1]}}, {3{take[0]}}};
    last  = timer == 8'(TIMEOUT - 1);
    cnt   = popcnt(rcv);
    maj   = 3'd0;
    for (int b = 0; b < 3; b++)
      maj[b] = popcnt({store[12+b], store[9+b], store[6+b], store[3+b], store[b]}) > 3'd2;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ack       <= 5'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= 3'd0;
      count     <= 3'd0;
      timed_out <= 1'b0;
      timer     <= 8'd0;
      rcv       <= 5'd0;
      store     <= 15'd0;
    end else begin
      ack  <= take;
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state <= COLLECT;
          busy  <= 1'b1;
          timer <= 8'd0;
          rcv   <= 5'd0;
          store <= 15'd0;
        end
        COLLECT: begin
          store <= (store & ~tmask) | (ballots & tmask);
          rcv   <= rcv_n;
          timer <= timer + 8'd1;
          if (&rcv_n || last) state <= DECIDE;
        end
        DECIDE: begin
          result    <= maj;
          count     <= cnt;
          timed_out <= cnt != 3'd5;
          done      <= 1'b1;
          state     <= DONE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_vote_ctrl.sv
// tb_vote_ctrl: randomized and directed sessions checked against a per-voter ballot model
module tb_vote_ctrl;
  localparam int T = 4;
  logic        clk = 1'b0;
  logic        rst, start;
  logic [4:0]  vld;
  logic [14:0] ballots;
  logic [4:0]  ack;
  logic        busy, done;
  logic [2:0]  result, count;
  logic        timed_out;
  int          n_tests = 0, n_fail = 0;
  logic [4:0]  qv[$];
  logic [14:0] qb[$];
  bit          got[5];
  logic [2:0]  val[5];
  vote_ctrl #(.TIMEOUT(T)) dut (
    .clk(clk), .rst(rst), .start(start), .vld(vld), .ballots(ballots),
    .ack(ack), .busy(busy), .done(done), .result(result), .count(count),
    .timed_out(timed_out)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    n_tests++;
    if (o !== e) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, o, e);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic run_session();
    logic [4:0]  v, acc;
    logic [14:0] b;
    logic [2:0]  res;
    int k, cnt, s;
    foreach (got[i]) begin
      got[i] = 0;
      val[i] = 3'd0;
    end
    start = 1'b1;
    vld = 5'($urandom);
    ballots = 15'($urandom);
    tick();
    chk("busy_collect", 32'(busy), 32'd1);
    chk("ack_first", 32'(ack), 32'd0);
    k = 0;
    cnt = 0;
    do begin
      k++;
      v = qv.size() > 0 ? qv.pop_front() : 5'd0;
      b = qb.size() > 0 ? qb.pop_front() : 15'd0;
      start = 1'($urandom_range(0, 1));
      vld = v;
      ballots = b;
      acc = 5'd0;
      for (int i = 0; i < 5; i++)
        if (v[i] && !got[i]) begin
          got[i] = 1;
          val[i] = b[3*i +: 3];
          acc[i] = 1'b1;
        end
      tick();
      chk("ack", 32'(ack), 32'(acc));
      chk("done_early", 32'(done), 32'd0);
      chk("busy", 32'(busy), 32'd1);
      cnt = 0;
      foreach (got[i]) cnt += int'(got[i]);
    end while (cnt < 5 && k < T);
    qv.delete();
    qb.delete();
    res = 3'd0;
    for (int bb = 0; bb < 3; bb++) begin
      s = 0;
      for (int i = 0; i < 5; i++) if (got[i] && val[i][bb]) s++;
      res[bb] = s >= 3;
    end
    start = 1'($urandom_range(0, 1));
    vld = 5'($urandom);
    ballots = 15'($urandom);
    tick();
    chk("done", 32'(done), 32'd1);
    chk("ack_decide", 32'(ack), 32'd0);
    chk("result", 32'(result), 32'(res));
    chk("count", 32'(count), 32'(cnt));
    chk("timed_out", 32'(timed_out), 32'(cnt < 5));
    start = 1'b1;
    vld = 5'($urandom);
    tick();
    chk("busy_idle", 32'(busy), 32'd0);
    chk("done_pulse", 32'(done), 32'd0);
    chk("result_hold", 32'(result), 32'(res));
    start = 1'b0;
    tick();
    chk("start_in_done_ignored", 32'(busy), 32'd0);
  endtask
  initial begin
    rst = 1'b1;
    start = 1'b1;
    vld = 5'b11111;
    ballots = 15'h7fff;
    tick();
    tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_timed_out", 32'(timed_out), 32'd0);
    rst = 1'b0;
    start = 1'b0;
    tick();
    qv = '{5'b11111};
    qb = '{{3'b001, 3'b011, 3'b100, 3'b101, 3'b101}};
    run_session();
    start = 1'b1;
    vld = 5'd0;
    tick();
    vld = 5'b00101;
    ballots = 15'($urandom);
    start = 1'b0;
    tick();
    chk("rst_pre_ack", 32'(ack), 32'b00101);
    rst = 1'b1;
    start = 1'b1;
    vld = 5'b11111;
    tick();
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_ack", 32'(ack), 32'd0);
    chk("abort_result", 32'(result), 32'd0);
    chk("abort_count", 32'(count), 32'd0);
    chk("abort_timed_out", 32'(timed_out), 32'd0);
    rst = 1'b0;
    start = 1'b0;
    vld = 5'd0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("abort_no_done", 32'(done), 32'd0);
    end
    qv = '{5'b01010};
    qb = '{15'($urandom)};
    run_session();
    qv = '{5'b00111, 5'd0, 5'd0, 5'b01000};
    qb = '{{3'b000, 3'b000, 3'b111, 3'b111, 3'b111}, 15'd0, 15'd0, 15'd0};
    run_session();
    qv = '{5'b00010, 5'b00111};
    qb = '{{9'd0, 3'b110, 3'b000}, {6'd0, 3'b110, 3'b001, 3'b110}};
    run_session();
    run_session();
    for (int n = 0; n < 25; n++) begin
      for (int c = 0; c < T; c++) begin
        qv.push_back(5'($urandom) & 5'($urandom));
        qb.push_back(15'($urandom));
      end
      run_session();
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
